// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl: runs one SNN inference per NEW_IMAGE rising edge. Each inference streams the image to the core once per timestep, waits for the core's done, then holds its digit.
// Optional WAIT_CORE watchdog: define SNN_TIMEOUT_EN.
module snn_inference_ctrl #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = 8,
    parameter int PIXEL_BITS      = 8,
    parameter int NUM_TIMESTEPS   = 16,
    parameter int TS_BITS         = 4,
    parameter int DIGIT_BITS      = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       NEW_IMAGE,
    input  logic [PIXEL_BITS-1:0]      IMAGE [IMAGE_SIZE],
    output logic                       CORE_START,
    output logic                       PIXEL_VALID,
    input  logic                       PIXEL_READY,
    output logic [IMAGE_SIZE_BITS-1:0] PIXEL_ADDR,
    output logic [PIXEL_BITS-1:0]      PIXEL_DATA,
    output logic [TS_BITS-1:0]         TIMESTEP,
    output logic                       TS_LAST_PIXEL,
    input  logic                       CORE_DONE,
    input  logic [DIGIT_BITS-1:0]      CORE_DIGIT,
    output logic                       BUSY,
    output logic                       COPROCESSOR_RDY,
    output logic [DIGIT_BITS-1:0]      INFERED_DIGIT
);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        WAIT_CORE,
        DONE
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       nimg_q;
    logic                       start;
    logic                       take_start;
    logic                       hs;
    logic                       last_addr;
    logic                       last_ts;
    logic                       wd_timeout;
    logic [IMAGE_SIZE_BITS-1:0] addr_q;
    logic [TS_BITS-1:0]         ts_q;
    logic                       core_start_q;
    logic                       rdy_q;
    logic [DIGIT_BITS-1:0]      digit_q;

    if (NUM_TIMESTEPS < 1) begin : g_bad_timesteps
        $error("snn_inference_ctrl: NUM_TIMESTEPS must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("snn_inference_ctrl: TIMEOUT_CYCLES must be >= 1");
    end
    if ((64'd1 << IMAGE_SIZE_BITS) < IMAGE_SIZE) begin : g_bad_addr_width
        $error("snn_inference_ctrl: IMAGE_SIZE_BITS too narrow for IMAGE_SIZE");
    end
    if ((64'd1 << TS_BITS) < NUM_TIMESTEPS) begin : g_bad_ts_width
        $error("snn_inference_ctrl: TS_BITS too narrow for NUM_TIMESTEPS");
    end

    // A start is honoured only when no inference is in flight; edges in ENCODE/WAIT_CORE are dropped.
    assign start      = NEW_IMAGE & ~nimg_q;
    assign take_start = start && (state_q == IDLE || state_q == DONE);
    assign hs         = (state_q == ENCODE) && PIXEL_READY;
    assign last_addr  = (addr_q == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1));
    assign last_ts    = (ts_q == TS_BITS'(NUM_TIMESTEPS - 1));

`ifdef SNN_TIMEOUT_EN
    localparam int WD_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_BITS-1:0] wd_cnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_cnt_q <= '0;
        end else if (state_q != WAIT_CORE) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign wd_timeout = (state_q == WAIT_CORE) && (wd_cnt_q == WD_BITS'(TIMEOUT_CYCLES - 1));
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = ENCODE;
            ENCODE:    if (hs && last_addr && last_ts) state_d = WAIT_CORE;
            WAIT_CORE: if (CORE_DONE || wd_timeout) state_d = DONE;
            DONE:      if (start) state_d = ENCODE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            nimg_q       <= 1'b0;
            core_start_q <= 1'b0;
            addr_q       <= '0;
            ts_q         <= '0;
            rdy_q        <= 1'b0;
            digit_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            nimg_q       <= NEW_IMAGE;
            core_start_q <= take_start;

            if (take_start) begin
                addr_q <= '0;
                ts_q   <= '0;
                rdy_q  <= 1'b0;
            end else if (hs) begin
                if (last_addr) begin
                    addr_q <= '0;
                    ts_q   <= last_ts ? '0 : ts_q + 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end

            // CORE_DONE takes priority over a watchdog expiry landing on the same cycle.
            if (state_q == WAIT_CORE) begin
                if (CORE_DONE) begin
                    digit_q <= CORE_DIGIT;
                    rdy_q   <= 1'b1;
                end else if (wd_timeout) begin
                    digit_q <= '1;
                    rdy_q   <= 1'b1;
                end
            end
        end
    end

    // Pixel outputs are gated so nothing leaks toward the core outside ENCODE.
    assign PIXEL_VALID     = (state_q == ENCODE);
    assign PIXEL_ADDR      = addr_q;
    assign PIXEL_DATA      = PIXEL_VALID ? IMAGE[addr_q] : '0;
    assign TIMESTEP        = ts_q;
    assign TS_LAST_PIXEL   = PIXEL_VALID && last_addr;
    assign CORE_START      = core_start_q;
    assign BUSY            = (state_q == ENCODE) || (state_q == WAIT_CORE);
    assign COPROCESSOR_RDY = rdy_q;
    assign INFERED_DIGIT   = digit_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// tb_snn_inference_ctrl: randomized bench for snn_inference_ctrl. The k-th accepted pixel of an inference is expected at address k mod IMAGE_SIZE and timestep k / IMAGE_SIZE.
// Define SNN_TIMEOUT_EN to also exercise the watchdog with a 64-cycle limit.
module tb_snn_inference_ctrl;

    localparam int IMAGE_SIZE      = 256;
    localparam int IMAGE_SIZE_BITS = 8;
    localparam int PIXEL_BITS      = 8;
    localparam int NUM_TIMESTEPS   = 16;
    localparam int TS_BITS         = 4;
    localparam int DIGIT_BITS      = 8;
`ifdef SNN_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES  = 64;
`else
    localparam int TIMEOUT_CYCLES  = 4096;
`endif
    localparam int TOTAL           = IMAGE_SIZE * NUM_TIMESTEPS;

    logic                       ACLK;
    logic                       ARESETN;
    logic                       NEW_IMAGE;
    logic [PIXEL_BITS-1:0]      image [IMAGE_SIZE];
    logic                       CORE_START;
    logic                       PIXEL_VALID;
    logic                       PIXEL_READY;
    logic [IMAGE_SIZE_BITS-1:0] PIXEL_ADDR;
    logic [PIXEL_BITS-1:0]      PIXEL_DATA;
    logic [TS_BITS-1:0]         TIMESTEP;
    logic                       TS_LAST_PIXEL;
    logic                       CORE_DONE;
    logic [DIGIT_BITS-1:0]      CORE_DIGIT;
    logic                       BUSY;
    logic                       COPROCESSOR_RDY;
    logic [DIGIT_BITS-1:0]      INFERED_DIGIT;

    int n_vec = 0;
    int n_err = 0;

    // Reference-model state, driven by what the bench expects an inference to look like.
    int          hs_idx       = 0;
    int          start_pulses = 0;
    int          valid_cycles = 0;
    bit          mon_en       = 0;
    bit          prev_stall   = 0;
    logic [31:0] prev_addr    = 0;
    logic [31:0] prev_data    = 0;
    int          rdy_mode     = 0;

    snn_inference_ctrl #(
        .IMAGE_SIZE      (IMAGE_SIZE),
        .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
        .PIXEL_BITS      (PIXEL_BITS),
        .NUM_TIMESTEPS   (NUM_TIMESTEPS),
        .TS_BITS         (TS_BITS),
        .DIGIT_BITS      (DIGIT_BITS),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .NEW_IMAGE       (NEW_IMAGE),
        .IMAGE           (image),
        .CORE_START      (CORE_START),
        .PIXEL_VALID     (PIXEL_VALID),
        .PIXEL_READY     (PIXEL_READY),
        .PIXEL_ADDR      (PIXEL_ADDR),
        .PIXEL_DATA      (PIXEL_DATA),
        .TIMESTEP        (TIMESTEP),
        .TS_LAST_PIXEL   (TS_LAST_PIXEL),
        .CORE_DONE       (CORE_DONE),
        .CORE_DIGIT      (CORE_DIGIT),
        .BUSY            (BUSY),
        .COPROCESSOR_RDY (COPROCESSOR_RDY),
        .INFERED_DIGIT   (INFERED_DIGIT)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: every accepted pixel is compared with the model sequence.
    always @(negedge ACLK) begin
        if (mon_en) begin
            if (CORE_START) start_pulses++;
            if (PIXEL_VALID) valid_cycles++;
            if (prev_stall) begin
                check("stall_valid", 32'(PIXEL_VALID), 32'd1);
                check("stall_addr", 32'(PIXEL_ADDR), prev_addr);
                check("stall_data", 32'(PIXEL_DATA), prev_data);
            end
            if (PIXEL_VALID && PIXEL_READY) begin
                if (hs_idx < TOTAL) begin
                    check("hs_addr", 32'(PIXEL_ADDR), 32'(hs_idx % IMAGE_SIZE));
                    check("hs_ts", 32'(TIMESTEP), 32'(hs_idx / IMAGE_SIZE));
                    check("hs_data", 32'(PIXEL_DATA), 32'(image[hs_idx % IMAGE_SIZE]));
                    check("hs_last", 32'(TS_LAST_PIXEL),
                          32'((hs_idx % IMAGE_SIZE) == IMAGE_SIZE - 1));
                end else begin
                    check("hs_overrun", 32'(hs_idx), 32'(TOTAL - 1));
                end
                hs_idx++;
            end
            prev_stall = PIXEL_VALID && !PIXEL_READY;
            prev_addr  = 32'(PIXEL_ADDR);
            prev_data  = 32'(PIXEL_DATA);
        end
    end

    initial begin
        PIXEL_READY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                0:       PIXEL_READY = 1'b1;
                1:       PIXEL_READY = ~PIXEL_READY;
                default: PIXEL_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic fill_image();
        for (int i = 0; i < IMAGE_SIZE; i++) image[i] = PIXEL_BITS'($urandom);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_core_start"}, 32'(CORE_START), 32'd0);
        check({pfx, "_valid"}, 32'(PIXEL_VALID), 32'd0);
        check({pfx, "_addr"}, 32'(PIXEL_ADDR), 32'd0);
        check({pfx, "_data"}, 32'(PIXEL_DATA), 32'd0);
        check({pfx, "_ts"}, 32'(TIMESTEP), 32'd0);
        check({pfx, "_last"}, 32'(TS_LAST_PIXEL), 32'd0);
        check({pfx, "_busy"}, 32'(BUSY), 32'd0);
        check({pfx, "_rdy"}, 32'(COPROCESSOR_RDY), 32'd0);
        check({pfx, "_digit"}, 32'(INFERED_DIGIT), 32'd0);
    endtask

    // Produce a fresh NEW_IMAGE rising edge and check the first ENCODE cycle.
    task automatic start_inference();
        hs_idx       = 0;
        start_pulses = 0;
        valid_cycles = 0;
        NEW_IMAGE    = 1'b0;
        tick();
        NEW_IMAGE = 1'b1;
        tick();
        @(negedge ACLK);
        check("start_pulse", 32'(CORE_START), 32'd1);
        check("start_valid", 32'(PIXEL_VALID), 32'd1);
        check("start_busy", 32'(BUSY), 32'd1);
        check("start_rdy_clear", 32'(COPROCESSOR_RDY), 32'd0);
        check("start_addr", 32'(PIXEL_ADDR), 32'd0);
        check("start_ts", 32'(TIMESTEP), 32'd0);
    endtask

    task automatic wait_core_phase();
        bit found = 0;
        for (int i = 0; i < 3 * TOTAL + 100; i++) begin
            @(negedge ACLK);
            if (BUSY && !PIXEL_VALID) begin
                found = 1;
                break;
            end
        end
        check("reach_wait_core", 32'(found), 32'd1);
        check("stream_len", 32'(hs_idx), 32'(TOTAL));
        check("single_core_start", 32'(start_pulses), 32'd1);
    endtask

    task automatic finish_core(input logic [DIGIT_BITS-1:0] digit, input int delay);
        repeat (delay) tick();
        CORE_DONE  = 1'b1;
        CORE_DIGIT = digit;
        @(negedge ACLK);
        check("rdy_not_before_done", 32'(COPROCESSOR_RDY), 32'd0);
        tick();
        CORE_DONE  = 1'b0;
        CORE_DIGIT = DIGIT_BITS'($urandom);
        @(negedge ACLK);
        check("done_rdy", 32'(COPROCESSOR_RDY), 32'd1);
        check("done_digit", 32'(INFERED_DIGIT), 32'(digit));
        check("done_busy", 32'(BUSY), 32'd0);
        check("done_valid", 32'(PIXEL_VALID), 32'd0);
    endtask

    initial begin
        bit seen;
        logic [DIGIT_BITS-1:0] d;

        ARESETN    = 1'b0;
        NEW_IMAGE  = 1'b0;
        CORE_DONE  = 1'b0;
        CORE_DIGIT = '0;
        fill_image();
        image[0] = 8'hA5;
        repeat (3) @(posedge ACLK);
        #1;
        check_outputs_zero("reset");
        ARESETN = 1'b1;
        repeat (3) tick();
        check_outputs_zero("post_reset");
        mon_en = 1;

        // T1: READY high, CORE_DONE coincident with the last pixel is ignored, digit 5 after 100 cycles.
        rdy_mode = 0;
        start_inference();
        seen = 0;
        for (int i = 0; i < TOTAL + 50; i++) begin
            tick();
            if (PIXEL_VALID && TS_LAST_PIXEL && TIMESTEP == TS_BITS'(NUM_TIMESTEPS - 1)) begin
                CORE_DONE  = 1'b1;
                CORE_DIGIT = 8'd9;
                tick();
                CORE_DONE  = 1'b0;
                seen       = 1;
                break;
            end
        end
        check("t1_saw_last_pixel", 32'(seen), 32'd1);
        wait_core_phase();
        check("t1_valid_cycles", 32'(valid_cycles), 32'(TOTAL));
        check("t1_early_done_ignored", 32'(COPROCESSOR_RDY), 32'd0);
        finish_core(8'd5, 100);

        // T2: READY toggling; pixel 57 carries 32 on every timestep.
        rdy_mode = 1;
        fill_image();
        image[57] = 8'd32;
        start_inference();
        wait_core_phase();
        finish_core(DIGIT_BITS'($urandom), int'($urandom_range(0, 20)));

        // T3: random READY, extra NEW_IMAGE edge mid-stream is ignored.
        rdy_mode = 2;
        fill_image();
        start_inference();
        for (int i = 0; i < 4 * TOTAL && hs_idx < 100; i++) tick();
        NEW_IMAGE = 1'b0;
        tick();
        NEW_IMAGE = 1'b1;
        tick();
        check("t3_still_busy", 32'(BUSY), 32'd1);
        wait_core_phase();
        finish_core(DIGIT_BITS'($urandom), int'($urandom_range(0, 20)));

        // T4: new edge from DONE clears RDY, next inference latches 7.
        check("t4_rdy_held", 32'(COPROCESSOR_RDY), 32'd1);
        start_inference();
        wait_core_phase();
        finish_core(8'd7, int'($urandom_range(1, 30)));

        // T5: reset at timestep 3, address 200 aborts at once; restart needs a fresh edge.
        rdy_mode = 0;
        fill_image();
        start_inference();
        seen = 0;
        for (int i = 0; i < TOTAL + 50; i++) begin
            tick();
            if (TIMESTEP == TS_BITS'(3) && PIXEL_ADDR == IMAGE_SIZE_BITS'(200)) begin
                seen = 1;
                break;
            end
        end
        check("t5_reached_abort_point", 32'(seen), 32'd1);
        mon_en  = 0;
        ARESETN = 1'b0;
        #1;
        check_outputs_zero("t5_abort");
        NEW_IMAGE = 1'b0;
        repeat (2) tick();
        ARESETN    = 1'b1;
        prev_stall = 0;
        mon_en     = 1;
        start_pulses = 0;
        repeat (5) tick();
        check("t5_idle_busy", 32'(BUSY), 32'd0);
        check("t5_no_start", 32'(start_pulses), 32'd0);
        start_inference();
        wait_core_phase();
        d = DIGIT_BITS'($urandom);
        finish_core(d, 3);

`ifdef SNN_TIMEOUT_EN
        // T6: no CORE_DONE, watchdog completes after TIMEOUT_CYCLES in WAIT_CORE.
        rdy_mode = 2;
        start_inference();
        wait_core_phase();
        repeat (TIMEOUT_CYCLES - 1) @(negedge ACLK);
        check("t6_rdy_before_timeout", 32'(COPROCESSOR_RDY), 32'd0);
        @(negedge ACLK);
        check("t6_timeout_rdy", 32'(COPROCESSOR_RDY), 32'd1);
        check("t6_timeout_digit", 32'(INFERED_DIGIT), 32'hFF);
        check("t6_timeout_busy", 32'(BUSY), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
